// File: rtl/multi_lane_psum_engine.sv
// Multi-lane MAC with per-lane psum scratchpads: one ifmap value is broadcast to
// LANES filter lanes, and the completed sums leave through a one-entry valid/ready output.
module multi_lane_psum_engine #(
    parameter int LANES        = 4,
    parameter int IF_WIDTH     = 6,
    parameter int FILTER_WIDTH = 8,
    parameter int PSUM_WIDTH   = 16,
    parameter int PSUM_DEPTH   = 16,
    parameter int ADDR_WIDTH   = $clog2(PSUM_DEPTH),
    parameter int SATURATE     = 1
) (
    input  logic                          clk,
    input  logic                          global_rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IF_WIDTH-1:0]           if_data,
    input  logic [LANES*FILTER_WIDTH-1:0] filter_data,
    input  logic [ADDR_WIDTH-1:0]         psum_addr,
    input  logic                          first_pass,
    input  logic                          last_pass,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*PSUM_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [LANES-1:0]              overflow,
    input  logic                          clear_overflow,
    output logic                          busy
);

    logic                          stall;

    logic                          s1_valid;
    logic                          s1_first;
    logic                          s1_last;
    logic [IF_WIDTH-1:0]           s1_if;
    logic [LANES*FILTER_WIDTH-1:0] s1_filter;
    logic [ADDR_WIDTH-1:0]         s1_addr;

    logic                          s2_valid;
    logic                          s2_first;
    logic                          s2_last;
    logic [ADDR_WIDTH-1:0]         s2_addr;
    logic [PSUM_WIDTH:0]           s2_prod [LANES];

    logic [PSUM_WIDTH:0]           prod_next [LANES];
    logic [PSUM_WIDTH-1:0]         pad_rd    [LANES];
    logic [PSUM_WIDTH:0]           lane_sum  [LANES];
    logic [PSUM_WIDTH-1:0]         lane_res  [LANES];
    logic [LANES-1:0]              lane_ovf;

    logic [PSUM_WIDTH-1:0]         pad [LANES][PSUM_DEPTH];

    // A last_pass result can only retire into an empty or draining output register.
    assign stall    = s2_valid && s2_last && out_valid && !out_ready;
    assign in_ready = !stall && !global_rst;
    assign busy     = s1_valid || s2_valid || out_valid;

    always_comb begin
        lane_ovf = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            prod_next[l] = (PSUM_WIDTH+1)'(s1_if)
                         * (PSUM_WIDTH+1)'(s1_filter[l*FILTER_WIDTH +: FILTER_WIDTH]);
            pad_rd[l]    = s2_first ? '0 : pad[l][s2_addr];
            lane_sum[l]  = (PSUM_WIDTH+1)'(pad_rd[l]) + s2_prod[l];
            lane_ovf[l]  = lane_sum[l][PSUM_WIDTH];
            lane_res[l]  = (SATURATE != 0 && lane_ovf[l]) ? '1 : lane_sum[l][PSUM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_if     <= '0;
            s1_filter <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            overflow  <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                s2_prod[l] <= '0;
                for (int unsigned a = 0; a < PSUM_DEPTH; a++) begin
                    pad[l][a] <= '0;
                end
            end
        end else begin
            if (!stall) begin
                s1_valid  <= in_valid;
                s1_first  <= first_pass;
                s1_last   <= last_pass;
                s1_if     <= if_data;
                s1_filter <= filter_data;
                s1_addr   <= psum_addr;
                s2_valid  <= s1_valid;
                s2_first  <= s1_first;
                s2_last   <= s1_last;
                s2_addr   <= s1_addr;
                for (int unsigned l = 0; l < LANES; l++) begin
                    s2_prod[l] <= prod_next[l];
                    if (s2_valid && !s2_last) begin
                        pad[l][s2_addr] <= lane_res[l];
                    end
                end
            end

            for (int unsigned l = 0; l < LANES; l++) begin
                if (s2_valid && !stall && lane_ovf[l]) begin
                    overflow[l] <= 1'b1;
                end else if (clear_overflow) begin
                    overflow[l] <= 1'b0;
                end
            end

            // A new result loading on a handshake edge keeps out_valid high.
            if (s2_valid && s2_last && !stall) begin
                out_valid <= 1'b1;
                out_addr  <= s2_addr;
                for (int unsigned l = 0; l < LANES; l++) begin
                    out_data[l*PSUM_WIDTH +: PSUM_WIDTH] <= lane_res[l];
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_lane_psum_engine.sv
// Directed bench for multi_lane_psum_engine: default build plus 14-bit saturating
// and 14-bit wrapping builds, all driven from the same stimulus.
module tb_multi_lane_psum_engine;

    logic        clk = 1'b0;
    logic        global_rst;
    logic        in_valid;
    logic [5:0]  if_data;
    logic [31:0] filter_data;
    logic [3:0]  psum_addr;
    logic        first_pass;
    logic        last_pass;
    logic        out_ready;
    logic        clear_overflow;

    logic        in_ready, out_valid, busy;
    logic [63:0] out_data;
    logic [3:0]  out_addr;
    logic [3:0]  overflow;

    logic        in_ready_s, out_valid_s, busy_s;
    logic [55:0] out_data_s;
    logic [3:0]  out_addr_s;
    logic [3:0]  overflow_s;

    logic        in_ready_w, out_valid_w, busy_w;
    logic [55:0] out_data_w;
    logic [3:0]  out_addr_w;
    logic [3:0]  overflow_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_lane_psum_engine dut (
        .clk(clk), .global_rst(global_rst), .in_valid(in_valid), .in_ready(in_ready),
        .if_data(if_data), .filter_data(filter_data), .psum_addr(psum_addr),
        .first_pass(first_pass), .last_pass(last_pass), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .overflow(overflow), .clear_overflow(clear_overflow), .busy(busy)
    );

    multi_lane_psum_engine #(.PSUM_WIDTH(14), .SATURATE(1)) dut_sat (
        .clk(clk), .global_rst(global_rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .if_data(if_data), .filter_data(filter_data), .psum_addr(psum_addr),
        .first_pass(first_pass), .last_pass(last_pass), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_addr(out_addr_s),
        .overflow(overflow_s), .clear_overflow(clear_overflow), .busy(busy_s)
    );

    multi_lane_psum_engine #(.PSUM_WIDTH(14), .SATURATE(0)) dut_wrap (
        .clk(clk), .global_rst(global_rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .if_data(if_data), .filter_data(filter_data), .psum_addr(psum_addr),
        .first_pass(first_pass), .last_pass(last_pass), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_addr(out_addr_w),
        .overflow(overflow_w), .clear_overflow(clear_overflow), .busy(busy_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one beat and advances to the next falling edge (beat accepted in between).
    task automatic drive(input logic [5:0] ifv, input logic [31:0] filt,
                         input logic [3:0] addr, input logic first, input logic last);
        in_valid    = 1'b1;
        if_data     = ifv;
        filter_data = filt;
        psum_addr   = addr;
        first_pass  = first;
        last_pass   = last;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        first_pass = 1'b0;
        last_pass  = 1'b0;
    endtask

    initial begin
        global_rst     = 1'b1;
        in_valid       = 1'b0;
        if_data        = '0;
        filter_data    = '0;
        psum_addr      = '0;
        first_pass     = 1'b0;
        last_pass      = 1'b0;
        out_ready      = 1'b1;
        clear_overflow = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        global_rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_after", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_addr", {60'd0, out_addr}, 64'd0);
        check("rst_overflow", {60'd0, overflow}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // Single first+last beat
        drive(6'd5, {8'd4, 8'd3, 8'd2, 8'd1}, 4'd2, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        check("single_not_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("single_valid", {63'd0, out_valid}, 64'd1);
        check("single_data", out_data, {16'd20, 16'd15, 16'd10, 16'd5});
        check("single_addr", {60'd0, out_addr}, 64'd2);
        check("single_ovf", {60'd0, overflow}, 64'd0);

        // Back-to-back accumulation on addr 7 with an interleaved addr 8 beat
        drive(6'd3, 32'h0000_000A, 4'd7, 1'b1, 1'b0);
        drive(6'd3, 32'h0000_000A, 4'd7, 1'b0, 1'b0);
        drive(6'd3, 32'h0000_0032, 4'd8, 1'b1, 1'b0);
        drive(6'd3, 32'h0000_000A, 4'd7, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("acc_not_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("acc_valid", {63'd0, out_valid}, 64'd1);
        check("acc_data", out_data, 64'd90);
        check("acc_addr", {60'd0, out_addr}, 64'd7);
        drive(6'd0, 32'h0, 4'd8, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check("acc_addr8_data", out_data, 64'd150);
        check("acc_addr8_addr", {60'd0, out_addr}, 64'd8);

        // Overflow: three 63*255 beats to addr 0; exact sum 48195
        drive(6'd63, 32'h0000_00FF, 4'd0, 1'b1, 1'b0);
        drive(6'd63, 32'h0000_00FF, 4'd0, 1'b0, 1'b0);
        drive(6'd63, 32'h0000_00FF, 4'd0, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check("ovf_main_data", out_data, 64'd48195);
        check("ovf_sat_data", {8'd0, out_data_s}, 64'd16383);
        check("ovf_wrap_data", {8'd0, out_data_w}, 64'd15427);
        check("ovf_main_flag", {60'd0, overflow}, 64'd0);
        check("ovf_sat_flag", {60'd0, overflow_s}, 64'd1);
        check("ovf_wrap_flag", {60'd0, overflow_w}, 64'd1);
        @(negedge clk);
        check("ovf_sat_sticky", {60'd0, overflow_s}, 64'd1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("clr_sat_flag", {60'd0, overflow_s}, 64'd0);
        check("clr_wrap_flag", {60'd0, overflow_w}, 64'd0);

        // Clear coincides with a new overflow commit in S2
        drive(6'd63, 32'h0000_00FF, 4'd0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("setclr_sat_flag", {60'd0, overflow_s}, 64'd1);
        check("setclr_wrap_flag", {60'd0, overflow_w}, 64'd1);
        check("setclr_main_flag", {60'd0, overflow}, 64'd0);
        check("setclr_sat_data", {8'd0, out_data_s}, 64'd16383);
        check("setclr_wrap_data", {8'd0, out_data_w}, 64'd15427);
        check("setclr_main_data", out_data, 64'd48195);

        // Backpressure with two last_pass beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        drive(6'd2, 32'h0000_000A, 4'd3, 1'b1, 1'b1);
        drive(6'd2, 32'h0000_0014, 4'd4, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_first_data", out_data, 64'd20);
        check("bp_first_addr", {60'd0, out_addr}, 64'd3);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        repeat (3) @(negedge clk);
        check("bp_hold_data", out_data, 64'd20);
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_valid", {63'd0, out_valid}, 64'd1);
        check("bp_second_data", out_data, 64'd40);
        check("bp_second_addr", {60'd0, out_addr}, 64'd4);
        @(negedge clk);
        check("bp_drained_valid", {63'd0, out_valid}, 64'd0);
        check("bp_drained_busy", {63'd0, busy}, 64'd0);

        // Reset with S1, S2 and output all occupied
        out_ready = 1'b0;
        drive(6'd1, 32'h0101_0101, 4'd5, 1'b1, 1'b1);
        drive(6'd1, 32'h0101_0101, 4'd6, 1'b1, 1'b1);
        drive(6'd1, 32'h0101_0101, 4'd9, 1'b1, 1'b0);
        idle();
        check("mid_busy_before", {63'd0, busy}, 64'd1);
        check("mid_valid_before", {63'd0, out_valid}, 64'd1);
        global_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_sat_ovf", {60'd0, overflow_s}, 64'd0);
        global_rst = 1'b0;
        out_ready  = 1'b1;
        drive(6'd1, 32'h0101_0101, 4'd7, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check("post_rst_data7", out_data, {16'd1, 16'd1, 16'd1, 16'd1});
        check("post_rst_addr7", {60'd0, out_addr}, 64'd7);
        drive(6'd0, 32'h0, 4'd8, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        check("post_rst_data8", out_data, 64'd0);
        check("post_rst_valid8", {63'd0, out_valid}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_lane_psum_engine.md
# multi_lane_psum_engine

Parametrised multi-filter MAC and partial-sum accumulation core, the successor to the single-lane multiplier/adder/psum-scratchpad path of the CNN PE. One ifmap value is broadcast to `LANES` filter lanes per beat. Each lane multiplies, accumulates into its own psum scratchpad entry and, on the final pass, emits the completed sum through a valid/ready output port. Saturating or wrapping arithmetic is selected by parameter, and overflow is reported per lane.

## Interface
- `LANES`, 4, number of parallel filter lanes
- `IF_WIDTH`, 6, ifmap operand width (unsigned)
- `FILTER_WIDTH`, 8, filter operand width (unsigned)
- `PSUM_WIDTH`, 16, accumulator and scratchpad word width; must be ≥ IF_WIDTH+FILTER_WIDTH
- `PSUM_DEPTH`, 16, psum scratchpad entries per lane
- `ADDR_WIDTH`, $clog2(PSUM_DEPTH), psum address width
- `SATURATE`, 1, 1 = clamp at 2^PSUM_WIDTH−1; 0 = wrap modulo 2^PSUM_WIDTH

Ports:
- `clk`  in  1  clock; single domain, rising edge
- `global_rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  engine accepts a beat this cycle
- `if_data`  in  IF_WIDTH  ifmap value, broadcast to all lanes
- `filter_data`  in  LANES*FILTER_WIDTH  lane n uses bits [n*FILTER_WIDTH +: FILTER_WIDTH]
- `psum_addr`  in  ADDR_WIDTH  scratchpad entry for this beat, shared by all lanes
- `first_pass`  in  1  ignore stored psum and treat it as 0
- `last_pass`  in  1  send the result to the output instead of the scratchpad
- `out_valid`  out  1  out_data/out_addr hold a completed result
- `out_ready`  in  1  consumer takes the result
- `out_data`  out  LANES*PSUM_WIDTH  per-lane final sums, packed like filter_data
- `out_addr`  out  ADDR_WIDTH  psum_addr of the emitted result
- `overflow`  out  LANES  sticky per-lane overflow flags
- `clear_overflow`  in  1  clear all overflow flags
- `busy`  out  1  any pipeline stage valid, or out_valid

## Operation
- Beat accepted on an edge where in_valid && in_ready.
- **S1 register**: captures operands, addr, first_pass, last_pass and a valid bit.
- **S2 register**: per lane, captures product = if_data × filter lane, width IF_WIDTH+FILTER_WIDTH, zero-extended to PSUM_WIDTH+1.
- **S2 combinational add**: sum = product + (first_pass ? 0 : pad[lane][addr]).
  - If sum ≥ 2^PSUM_WIDTH: overflow[lane] is set.
  - The result is clamped (SATURATE=1) or truncated (SATURATE=0).
- **S2 commit, last_pass=0**: pad[lane][addr] ← result.
- **S2 commit, last_pass=1**: result loaded into out_data and out_addr, out_valid ← 1; the pad entry is not written.
- first_pass and last_pass both set: output = product, saturated or truncated the same way.
- The pad is read and written in S2 only, so back-to-back beats to the same address see the updated value with no hazard and no bubble.
- **Stall** = S2 valid && S2 last_pass && out_valid && !out_ready.
  - While stalled, S1, S2 and the pad hold.
  - in_ready = !stall && !global_rst.
- **Output handshake**:
  - out_valid clears on out_valid && out_ready, unless a new last_pass result loads on the same edge; in that case out_valid stays 1 with the new data.
  - out_data is stable while out_valid && !out_ready.
- **Overflow**: set wins over a simultaneous clear_overflow in the same lane.
- **Reset**: clears all valid bits, out_valid, out_data, out_addr, overflow and every pad entry to 0. Reset mid-stream discards all in-flight beats and any pending output.

## Timing
- Latency: beat accepted at edge E0; product registered at E1; pad write or output load at E2. out_valid is first seen high in the cycle after E2.
- Throughput: 1 beat per cycle when not stalled.
- Output buffering: one entry. A continuous stream of last_pass beats sustains full rate only while out_ready=1.
- Reset values: in_ready 0 during reset and 1 after; out_valid 0; out_data 0; out_addr 0; overflow 0; busy 0.
- busy goes low in the cycle after the last output handshake with empty stages.

## Test plan
- **Single-pass output**: reset, then one beat with if=5, filters {1,2,3,4}, addr 2, first+last → out_valid exactly 2 edges later; out_data lanes {5,10,15,20}; out_addr 2; overflow 0.
- **Back-to-back accumulation**: three consecutive beats to addr 7, all with if=3 and filter lane0=10 (first; middle; last) → lane0 output 90, no bubbles; an interleaved beat to addr 8 must not disturb addr 7.
- **Saturation, SATURATE=1**: PSUM_WIDTH=14, repeated 63×255 beats → output clamps at 16383; overflow[0] sticky. A clear_overflow pulse clears it; a clear coinciding with a new overflow leaves the flag set.
- **Wrap, SATURATE=0**: same stimulus → result equals the exact sum mod 2^14, with overflow set.
- **Backpressure**: out_ready=0 with two last_pass beats in flight → in_ready drops when the second reaches S2. The first result holds stable; releasing out_ready delivers both in order with no loss or duplication.
- **Reset mid-operation**: assert global_rst with S1, S2 and output all valid → next cycle out_valid=0, busy=0, pads zero; a first_pass-less beat afterwards accumulates from 0.
